// File: rtl/rom_sbox.sv
// AES forward S-box ROM (FIPS-197 SubBytes table), 256 x 8.
// data_o is a zero-latency combinational lookup of rom_addr; data_r_o/v_r_o
// are a one-cycle registered copy for pipelined consumers.
//
// Handshake: v_i is a plain valid with no ready/backpressure. Every cycle
// with v_i=1 is accepted and its lookup appears on data_r_o with v_r_o=1
// one clock later; a cycle with v_i=0 leaves data_r_o unchanged and
// drops v_r_o.
module rom_sbox (
  input  logic       clk_i,
  input  logic       reset_n_i,
  input  logic [7:0] rom_addr,
  input  logic       v_i,
  output logic [7:0] data_o,
  output logic [7:0] data_r_o,
  output logic       v_r_o
);

  // Constant table lookup; every one of the 256 addresses is listed.
  function automatic logic [7:0] sbox_lookup(input logic [7:0] a);
    logic [7:0] s;
    case (a)
      8'h00: s = 8'h63;
      8'h01: s = 8'h7c;
      8'h02: s = 8'h77;
      8'h03: s = 8'h7b;
      8'h04: s = 8'hf2;
      8'h05: s = 8'h6b;
      8'h06: s = 8'h6f;
      8'h07: s = 8'hc5;
      8'h08: s = 8'h30;
      8'h09: s = 8'h01;
      8'h0a: s = 8'h67;
      8'h0b: s = 8'h2b;
      8'h0c: s = 8'hfe;
      8'h0d: s = 8'hd7;
      8'h0e: s = 8'hab;
      8'h0f: s = 8'h76;
      8'h10: s = 8'hca;
      8'h11: s = 8'h82;
      8'h12: s = 8'hc9;
      8'h13: s = 8'h7d;
      8'h14: s = 8'hfa;
      8'h15: s = 8'h59;
      8'h16: s = 8'h47;
      8'h17: s = 8'hf0;
      8'h18: s = 8'had;
      8'h19: s = 8'hd4;
      8'h1a: s = 8'ha2;
      8'h1b: s = 8'haf;
      8'h1c: s = 8'h9c;
      8'h1d: s = 8'ha4;
      8'h1e: s = 8'h72;
      8'h1f: s = 8'hc0;
      8'h20: s = 8'hb7;
      8'h21: s = 8'hfd;
      8'h22: s = 8'h93;
      8'h23: s = 8'h26;
      8'h24: s = 8'h36;
      8'h25: s = 8'h3f;
      8'h26: s = 8'hf7;
      8'h27: s = 8'hcc;
      8'h28: s = 8'h34;
      8'h29: s = 8'ha5;
      8'h2a: s = 8'he5;
      8'h2b: s = 8'hf1;
      8'h2c: s = 8'h71;
      8'h2d: s = 8'hd8;
      8'h2e: s = 8'h31;
      8'h2f: s = 8'h15;
      8'h30: s = 8'h04;
      8'h31: s = 8'hc7;
      8'h32: s = 8'h23;
      8'h33: s = 8'hc3;
      8'h34: s = 8'h18;
      8'h35: s = 8'h96;
      8'h36: s = 8'h05;
      8'h37: s = 8'h9a;
      8'h38: s = 8'h07;
      8'h39: s = 8'h12;
      8'h3a: s = 8'h80;
      8'h3b: s = 8'he2;
      8'h3c: s = 8'heb;
      8'h3d: s = 8'h27;
      8'h3e: s = 8'hb2;
      8'h3f: s = 8'h75;
      8'h40: s = 8'h09;
      8'h41: s = 8'h83;
      8'h42: s = 8'h2c;
      8'h43: s = 8'h1a;
      8'h44: s = 8'h1b;
      8'h45: s = 8'h6e;
      8'h46: s = 8'h5a;
      8'h47: s = 8'ha0;
      8'h48: s = 8'h52;
      8'h49: s = 8'h3b;
      8'h4a: s = 8'hd6;
      8'h4b: s = 8'hb3;
      8'h4c: s = 8'h29;
      8'h4d: s = 8'he3;
      8'h4e: s = 8'h2f;
      8'h4f: s = 8'h84;
      8'h50: s = 8'h53;
      8'h51: s = 8'hd1;
      8'h52: s = 8'h00;
      8'h53: s = 8'hed;
      8'h54: s = 8'h20;
      8'h55: s = 8'hfc;
      8'h56: s = 8'hb1;
      8'h57: s = 8'h5b;
      8'h58: s = 8'h6a;
      8'h59: s = 8'hcb;
      8'h5a: s = 8'hbe;
      8'h5b: s = 8'h39;
      8'h5c: s = 8'h4a;
      8'h5d: s = 8'h4c;
      8'h5e: s = 8'h58;
      8'h5f: s = 8'hcf;
      8'h60: s = 8'hd0;
      8'h61: s = 8'hef;
      8'h62: s = 8'haa;
      8'h63: s = 8'hfb;
      8'h64: s = 8'h43;
      8'h65: s = 8'h4d;
      8'h66: s = 8'h33;
      8'h67: s = 8'h85;
      8'h68: s = 8'h45;
      8'h69: s = 8'hf9;
      8'h6a: s = 8'h02;
      8'h6b: s = 8'h7f;
      8'h6c: s = 8'h50;
      8'h6d: s = 8'h3c;
      8'h6e: s = 8'h9f;
      8'h6f: s = 8'ha8;
      8'h70: s = 8'h51;
      8'h71: s = 8'ha3;
      8'h72: s = 8'h40;
      8'h73: s = 8'h8f;
      8'h74: s = 8'h92;
      8'h75: s = 8'h9d;
      8'h76: s = 8'h38;
      8'h77: s = 8'hf5;
      8'h78: s = 8'hbc;
      8'h79: s = 8'hb6;
      8'h7a: s = 8'hda;
      8'h7b: s = 8'h21;
      8'h7c: s = 8'h10;
      8'h7d: s = 8'hff;
      8'h7e: s = 8'hf3;
      8'h7f: s = 8'hd2;
      8'h80: s = 8'hcd;
      8'h81: s = 8'h0c;
      8'h82: s = 8'h13;
      8'h83: s = 8'hec;
      8'h84: s = 8'h5f;
      8'h85: s = 8'h97;
      8'h86: s = 8'h44;
      8'h87: s = 8'h17;
      8'h88: s = 8'hc4;
      8'h89: s = 8'ha7;
      8'h8a: s = 8'h7e;
      8'h8b: s = 8'h3d;
      8'h8c: s = 8'h64;
      8'h8d: s = 8'h5d;
      8'h8e: s = 8'h19;
      8'h8f: s = 8'h73;
      8'h90: s = 8'h60;
      8'h91: s = 8'h81;
      8'h92: s = 8'h4f;
      8'h93: s = 8'hdc;
      8'h94: s = 8'h22;
      8'h95: s = 8'h2a;
      8'h96: s = 8'h90;
      8'h97: s = 8'h88;
      8'h98: s = 8'h46;
      8'h99: s = 8'hee;
      8'h9a: s = 8'hb8;
      8'h9b: s = 8'h14;
      8'h9c: s = 8'hde;
      8'h9d: s = 8'h5e;
      8'h9e: s = 8'h0b;
      8'h9f: s = 8'hdb;
      8'ha0: s = 8'he0;
      8'ha1: s = 8'h32;
      8'ha2: s = 8'h3a;
      8'ha3: s = 8'h0a;
      8'ha4: s = 8'h49;
      8'ha5: s = 8'h06;
      8'ha6: s = 8'h24;
      8'ha7: s = 8'h5c;
      8'ha8: s = 8'hc2;
      8'ha9: s = 8'hd3;
      8'haa: s = 8'hac;
      8'hab: s = 8'h62;
      8'hac: s = 8'h91;
      8'had: s = 8'h95;
      8'hae: s = 8'he4;
      8'haf: s = 8'h79;
      8'hb0: s = 8'he7;
      8'hb1: s = 8'hc8;
      8'hb2: s = 8'h37;
      8'hb3: s = 8'h6d;
      8'hb4: s = 8'h8d;
      8'hb5: s = 8'hd5;
      8'hb6: s = 8'h4e;
      8'hb7: s = 8'ha9;
      8'hb8: s = 8'h6c;
      8'hb9: s = 8'h56;
      8'hba: s = 8'hf4;
      8'hbb: s = 8'hea;
      8'hbc: s = 8'h65;
      8'hbd: s = 8'h7a;
      8'hbe: s = 8'hae;
      8'hbf: s = 8'h08;
      8'hc0: s = 8'hba;
      8'hc1: s = 8'h78;
      8'hc2: s = 8'h25;
      8'hc3: s = 8'h2e;
      8'hc4: s = 8'h1c;
      8'hc5: s = 8'ha6;
      8'hc6: s = 8'hb4;
      8'hc7: s = 8'hc6;
      8'hc8: s = 8'he8;
      8'hc9: s = 8'hdd;
      8'hca: s = 8'h74;
      8'hcb: s = 8'h1f;
      8'hcc: s = 8'h4b;
      8'hcd: s = 8'hbd;
      8'hce: s = 8'h8b;
      8'hcf: s = 8'h8a;
      8'hd0: s = 8'h70;
      8'hd1: s = 8'h3e;
      8'hd2: s = 8'hb5;
      8'hd3: s = 8'h66;
      8'hd4: s = 8'h48;
      8'hd5: s = 8'h03;
      8'hd6: s = 8'hf6;
      8'hd7: s = 8'h0e;
      8'hd8: s = 8'h61;
      8'hd9: s = 8'h35;
      8'hda: s = 8'h57;
      8'hdb: s = 8'hb9;
      8'hdc: s = 8'h86;
      8'hdd: s = 8'hc1;
      8'hde: s = 8'h1d;
      8'hdf: s = 8'h9e;
      8'he0: s = 8'he1;
      8'he1: s = 8'hf8;
      8'he2: s = 8'h98;
      8'he3: s = 8'h11;
      8'he4: s = 8'h69;
      8'he5: s = 8'hd9;
      8'he6: s = 8'h8e;
      8'he7: s = 8'h94;
      8'he8: s = 8'h9b;
      8'he9: s = 8'h1e;
      8'hea: s = 8'h87;
      8'heb: s = 8'he9;
      8'hec: s = 8'hce;
      8'hed: s = 8'h55;
      8'hee: s = 8'h28;
      8'hef: s = 8'hdf;
      8'hf0: s = 8'h8c;
      8'hf1: s = 8'ha1;
      8'hf2: s = 8'h89;
      8'hf3: s = 8'h0d;
      8'hf4: s = 8'hbf;
      8'hf5: s = 8'he6;
      8'hf6: s = 8'h42;
      8'hf7: s = 8'h68;
      8'hf8: s = 8'h41;
      8'hf9: s = 8'h99;
      8'hfa: s = 8'h2d;
      8'hfb: s = 8'h0f;
      8'hfc: s = 8'hb0;
      8'hfd: s = 8'h54;
      8'hfe: s = 8'hbb;
      8'hff: s = 8'h16;
    endcase
    return s;
  endfunction

  // Combinational lookup, independent of clock, reset and v_i.
  always_comb begin
    data_o = sbox_lookup(rom_addr);
  end

  // Registered copy: capture on v_i, hold data otherwise; v_r_o marks a fresh capture.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      data_r_o <= 8'h00;
      v_r_o    <= 1'b0;
    end else begin
      v_r_o <= v_i;
      if (v_i) begin
        data_r_o <= data_o;
      end
    end
  end

endmodule

// File: tb/tb_rom_sbox.sv
// Directed testbench for rom_sbox. The reference S-box is computed
// independently (GF(2^8) inverse followed by the AES affine map) and
// backed by hand-entered anchor values.
module tb_rom_sbox;

  logic       clk_i;
  logic       reset_n_i;
  logic [7:0] rom_addr;
  logic       v_i;
  logic [7:0] data_o;
  logic [7:0] data_r_o;
  logic       v_r_o;

  logic       clk_run;
  int         n_checks;
  int         n_pass;

  rom_sbox dut (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .rom_addr  (rom_addr),
    .v_i       (v_i),
    .data_o    (data_o),
    .data_r_o  (data_r_o),
    .v_r_o     (v_r_o)
  );

  // Clock/reset: 10-unit period clock that can be paused for the no-clock sweep.
  initial clk_i = 1'b0;
  always begin
    #5;
    if (clk_run) clk_i = ~clk_i;
  end

  // Reference model: multiplication in GF(2^8) mod x^8+x^4+x^3+x+1.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  function automatic logic [7:0] model_sbox(input logic [7:0] a);
    logic [7:0] inv;
    inv = 8'h00;
    for (int b = 1; b < 256; b++) begin
      if (gf_mul(a, 8'(b)) == 8'h01) inv = 8'(b);
    end
    return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
  endfunction

  // Driver: advance one clock and settle just past the rising edge.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    reset_n_i = 1'b0;
    v_i       = 1'b1;
    rom_addr  = 8'h53;
    repeat (3) tick();
    n_checks++;
    if (data_r_o !== 8'h00) $display("FAIL reset_data_r: got %h want 00", data_r_o);
    else n_pass++;
    n_checks++;
    if (v_r_o !== 1'b0) $display("FAIL reset_v_r: got %b want 0", v_r_o);
    else n_pass++;
    n_checks++;
    if (data_o !== 8'hed) $display("FAIL reset_data_o: got %h want ed", data_o);
    else n_pass++;
  endtask

  task automatic test_anchors();
    logic [7:0] addr_tab [10] = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h0f, 8'h10, 8'h53, 8'h80, 8'hf0, 8'hff};
    logic [7:0] exp_tab  [10] = '{8'h63, 8'h7c, 8'h77, 8'h7b, 8'h76, 8'hca, 8'hed, 8'hcd, 8'h8c, 8'h16};
    for (int i = 0; i < 10; i++) begin
      rom_addr = addr_tab[i];
      #10;
      n_checks++;
      if (data_o !== exp_tab[i])
        $display("FAIL anchor[%h]: got %h want %h", addr_tab[i], data_o, exp_tab[i]);
      else n_pass++;
    end
  endtask

  task automatic test_sweep();
    bit seen [256];
    int dups;
    logic [7:0] exp;
    dups = 0;
    for (int i = 0; i < 256; i++) seen[i] = 1'b0;
    for (int a = 0; a < 256; a++) begin
      rom_addr = 8'(a);
      #10;
      exp = model_sbox(8'(a));
      n_checks++;
      if (data_o !== exp) $display("FAIL sweep[%h]: got %h want %h", a[7:0], data_o, exp);
      else n_pass++;
      if (!$isunknown(data_o)) begin
        if (seen[data_o]) dups++;
        seen[data_o] = 1'b1;
      end else begin
        dups++;
      end
    end
    n_checks++;
    if (dups !== 0) $display("FAIL bijection: got %0d duplicates want 0", dups);
    else n_pass++;
  endtask

  task automatic test_capture();
    clk_run = 1'b1;
    tick();
    reset_n_i = 1'b1;
    v_i       = 1'b1;
    rom_addr  = 8'h80;
    tick();
    n_checks++;
    if (data_r_o !== 8'hcd) $display("FAIL capture_data_r: got %h want cd", data_r_o);
    else n_pass++;
    n_checks++;
    if (v_r_o !== 1'b1) $display("FAIL capture_v_r: got %b want 1", v_r_o);
    else n_pass++;
  endtask

  task automatic test_hold();
    v_i      = 1'b1;
    rom_addr = 8'h10;
    tick();
    v_i      = 1'b0;
    rom_addr = 8'hf0;
    #1;
    n_checks++;
    if (data_o !== 8'h8c) $display("FAIL hold_data_o_now: got %h want 8c", data_o);
    else n_pass++;
    n_checks++;
    if (data_r_o !== 8'hca) $display("FAIL hold_pre_edge: got %h want ca", data_r_o);
    else n_pass++;
    tick();
    n_checks++;
    if (data_r_o !== 8'hca) $display("FAIL hold_data_r: got %h want ca", data_r_o);
    else n_pass++;
    n_checks++;
    if (v_r_o !== 1'b0) $display("FAIL hold_v_r: got %b want 0", v_r_o);
    else n_pass++;
    tick();
    n_checks++;
    if (data_r_o !== 8'hca) $display("FAIL hold_two_cycles: got %h want ca", data_r_o);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [7:0] addr_tab [6] = '{8'h00, 8'hff, 8'h53, 8'h01, 8'h0f, 8'h02};
    logic [7:0] exp_tab  [6] = '{8'h63, 8'h16, 8'hed, 8'h7c, 8'h76, 8'h77};
    v_i = 1'b1;
    for (int i = 0; i < 6; i++) begin
      rom_addr = addr_tab[i];
      tick();
      n_checks++;
      if (data_r_o !== exp_tab[i] || v_r_o !== 1'b1)
        $display("FAIL b2b[%0d]: got %h/%b want %h/1", i, data_r_o, v_r_o, exp_tab[i]);
      else n_pass++;
    end
  endtask

  task automatic test_async_reset();
    v_i      = 1'b1;
    rom_addr = 8'hff;
    tick();
    n_checks++;
    if (data_r_o !== 8'h16) $display("FAIL areset_setup: got %h want 16", data_r_o);
    else n_pass++;
    #2;
    reset_n_i = 1'b0;
    #1;
    n_checks++;
    if (data_r_o !== 8'h00) $display("FAIL areset_data_r: got %h want 00", data_r_o);
    else n_pass++;
    n_checks++;
    if (v_r_o !== 1'b0) $display("FAIL areset_v_r: got %b want 0", v_r_o);
    else n_pass++;
    n_checks++;
    if (data_o !== 8'h16) $display("FAIL areset_data_o: got %h want 16", data_o);
    else n_pass++;
    tick();
    n_checks++;
    if (data_r_o !== 8'h00 || v_r_o !== 1'b0)
      $display("FAIL areset_held: got %h/%b want 00/0", data_r_o, v_r_o);
    else n_pass++;
    reset_n_i = 1'b1;
    rom_addr  = 8'h53;
    tick();
    n_checks++;
    if (data_r_o !== 8'hed || v_r_o !== 1'b1)
      $display("FAIL areset_recover: got %h/%b want ed/1", data_r_o, v_r_o);
    else n_pass++;
  endtask

  initial begin
    n_checks  = 0;
    n_pass    = 0;
    clk_run   = 1'b1;
    reset_n_i = 1'b0;
    v_i       = 1'b0;
    rom_addr  = 8'h00;
    test_reset();
    clk_run = 1'b0;
    #20;
    test_anchors();
    test_sweep();
    test_capture();
    test_hold();
    test_back_to_back();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
